// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its IF/ID consumer.
package fetch_pkg;

  localparam int FETCH_WIDTH = 36;
  localparam int FETCH_IW    = 24;
  localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_IW-1:0]    instr;
    logic [FETCH_WIDTH-1:0] pc;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: bubble clears only the valid bit, load captures a new entry,
// neither asserted holds the current entry.
module ifid_reg #(
  parameter int W  = 36,
  parameter int IW = 24
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_bubble,
  input  logic [IW-1:0] i_instr,
  input  logic [W-1:0]  i_pc,
  input  logic          i_valid,
  output logic [IW-1:0] o_instr,
  output logic [W-1:0]  o_pc,
  output logic          o_valid
);

  logic [IW-1:0] r_instr;
  logic [W-1:0]  r_pc;
  logic          r_valid;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch in front of a 1-cycle synchronous instruction memory; tracks the address
// whose data is currently on imem_rdata so stalls and redirects never lose or repeat a fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH            = 36,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stall,
  input  logic                        halt_req,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            branch_target,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic [INSTRUCTIONWIDTH-1:0] instr_d,
  output logic [WIDTH-1:0]            pc_d,
  output logic                        valid_d,
  output logic                        halted,
  output logic [CNT_W-1:0]            fetch_count,
  output logic [1:0]                  dbg_state
);

  localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_state_t     r_state, w_state_n;
  logic [WIDTH-1:0] r_pc_f, w_pc_f_n;
  logic [WIDTH-1:0] r_pend_pc, w_pend_pc_n;
  logic             r_pend_valid, w_pend_valid_n;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_load, w_bubble, w_count_inc;

  always_comb begin
    w_state_n      = r_state;
    w_pc_f_n       = r_pc_f;
    w_pend_pc_n    = r_pend_pc;
    w_pend_valid_n = r_pend_valid;
    w_load         = 1'b0;
    w_bubble       = 1'b0;
    case (r_state)
      IDLE: begin
        w_bubble = 1'b1;
        if (start) begin
          w_state_n      = RUN;
          w_pend_pc_n    = RESET_PC;
          w_pend_valid_n = 1'b1;
          w_pc_f_n       = RESET_PC + PC_ONE;
        end
      end
      RUN: begin
        if (halt_req) begin
          w_bubble       = 1'b1;
          w_pend_valid_n = 1'b0;
          w_state_n      = HALT;
        end else if (branch_taken) begin
          // The redirect address is issued this cycle, so it becomes the pending fetch.
          w_bubble       = 1'b1;
          w_pend_pc_n    = branch_target;
          w_pend_valid_n = 1'b1;
          w_pc_f_n       = branch_target + PC_ONE;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_pend_pc_n = r_pc_f;
          w_pc_f_n    = r_pc_f + PC_ONE;
        end
      end
      HALT: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // During a stall the pending address is re-read so imem_rdata still matches pend_pc on release.
  always_comb begin
    imem_addr = r_pc_f;
    if (r_state == RUN) begin
      if (branch_taken)  imem_addr = branch_target;
      else if (stall)    imem_addr = r_pend_pc;
    end
  end

  assign w_count_inc = w_load && r_pend_valid && (r_fetch_count != '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc_f        <= RESET_PC;
      r_pend_pc     <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc_f       <= w_pc_f_n;
      r_pend_pc    <= w_pend_pc_n;
      r_pend_valid <= w_pend_valid_n;
      if (w_count_inc) r_fetch_count <= r_fetch_count + CNT_ONE;
    end
  end

  ifid_reg #(
    .W  (WIDTH),
    .IW (INSTRUCTIONWIDTH)
  ) u_ifid (
    .clk      (clk),
    .i_reset  (reset),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (imem_rdata),
    .i_pc     (r_pend_pc),
    .i_valid  (r_pend_valid),
    .o_instr  (instr_d),
    .o_pc     (pc_d),
    .o_valid  (valid_d)
  );

  assign halted      = (r_state == HALT);
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program-order reference model predicts the delivered instruction
// stream, and a negedge monitor checks the IF/ID outputs against it.
module tb_fetch_unit;

  localparam int W  = 36;
  localparam int IW = 24;
  localparam int EW = W + IW;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stall;
  logic          halt_req;
  logic          branch_taken;
  logic [W-1:0]  branch_target;
  logic [W-1:0]  imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr_d;
  logic [W-1:0]  pc_d;
  logic          valid_d;
  logic          halted;
  logic [15:0]   fetch_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .valid_d       (valid_d),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_val(input logic [W-1:0] a);
    case (a)
      36'd0:   return 24'h000011;
      36'd1:   return 24'h000022;
      36'd2:   return 24'h000033;
      36'd3:   return 24'h000044;
      36'd17:  return 24'h000025;
      default: return a[23:0] ^ {a[35:24], a[35:24]} ^ 24'h5A5A5A;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= mem_val(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            m_state = M_IDLE;
  logic [W-1:0]  m_next = '0;
  int            m_count = 0;
  logic          m_exp_valid = 1'b0;
  logic          m_held = 1'b0;
  logic [EW-1:0] m_last = '0;
  logic          m_init = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_state     = M_IDLE;
      exp_q.delete();
      m_count     = 0;
      m_held      = 1'b0;
      m_exp_valid = 1'b0;
      m_last      = '0;
      m_init      = 1'b1;
    end else begin
      m_held = 1'b0;
      case (m_state)
        M_IDLE: begin
          m_exp_valid = 1'b0;
          if (start) begin
            m_state = M_RUN;
            m_next  = '0;
          end
        end
        M_RUN: begin
          if (halt_req) begin
            m_state     = M_HALT;
            m_exp_valid = 1'b0;
          end else if (branch_taken) begin
            m_next      = branch_target;
            m_exp_valid = 1'b0;
          end else if (stall) begin
            m_held = 1'b1;
          end else begin
            m_last = {m_next, mem_val(m_next)};
            exp_q.push_back(m_last);
            m_next = m_next + 1'b1;
            if (m_count < 65535) m_count++;
            m_exp_valid = 1'b1;
          end
        end
        default: m_exp_valid = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (m_init) begin
      chk("valid_d", 64'(valid_d), 64'(m_exp_valid));
      chk("fetch_count", 64'(fetch_count), 64'(m_count));
      chk("halted", 64'(halted), 64'(m_state == M_HALT));
      if (valid_d) begin
        if (m_held) begin
          chk("hold_pc", 64'(pc_d), 64'(m_last[EW-1:IW]));
          chk("hold_instr", 64'(instr_d), 64'(m_last[IW-1:0]));
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: unexpected entry pc %h instr %h", pc_d, instr_d);
        end else begin
          e = exp_q.pop_front();
          chk("pc_d", 64'(pc_d), 64'(e[EW-1:IW]));
          chk("instr_d", 64'(instr_d), 64'(e[IW-1:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 64'(valid_d), 64'd0);
    chk({tag, "_pc"}, 64'(pc_d), 64'd0);
    chk({tag, "_instr"}, 64'(instr_d), 64'd0);
    chk({tag, "_count"}, 64'(fetch_count), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int r;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    chk_cleared("reset");
    reset = 1'b0;

    // Sequential fetch with a 3-cycle stall while pc_d=1
    start = 1'b1; #1;
    tick();
    start = 1'b0; #1;
    chk("first_bubble", 64'(valid_d), 64'd0);
    tick();
    chk("first_pc", 64'(pc_d), 64'd0);
    chk("first_instr", 64'(instr_d), 64'h11);
    tick();
    chk("second_pc", 64'(pc_d), 64'd1);
    stall = 1'b1; #1;
    chk("stall_addr", 64'(imem_addr), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", 64'(instr_d), 64'h22);
      chk("stall_addr_hold", 64'(imem_addr), 64'd2);
    end
    stall = 1'b0; #1;
    tick();
    chk("post_stall_pc", 64'(pc_d), 64'd2);
    chk("post_stall_instr", 64'(instr_d), 64'h33);
    tick();
    chk("seq_last_instr", 64'(instr_d), 64'h44);
    chk("seq_count", 64'(fetch_count), 64'd4);

    // Branch to 17
    branch_taken = 1'b1; branch_target = 36'd17; #1;
    chk("branch_addr", 64'(imem_addr), 64'd17);
    tick();
    branch_taken = 1'b0; #1;
    chk("branch_bubble", 64'(valid_d), 64'd0);
    tick();
    chk("branch_pc", 64'(pc_d), 64'd17);
    chk("branch_instr", 64'(instr_d), 64'h25);
    tick();
    chk("branch_next_pc", 64'(pc_d), 64'd18);

    // Branch during stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 36'd5; #1;
    chk("br_stall_addr", 64'(imem_addr), 64'd5);
    tick();
    stall = 1'b0; branch_taken = 1'b0; #1;
    chk("br_stall_bubble", 64'(valid_d), 64'd0);
    tick();
    chk("br_stall_pc", 64'(pc_d), 64'd5);

    // Wrap at all-ones
    branch_taken = 1'b1; branch_target = 36'hFFFFFFFFF; #1;
    tick();
    branch_taken = 1'b0; #1;
    tick();
    chk("wrap_top_pc", 64'(pc_d), 64'hFFFFFFFFF);
    tick();
    chk("wrap_zero_pc", 64'(pc_d), 64'd0);

    // Halt: inputs ignored, fetch address frozen at pc 2
    halt_req = 1'b1; #1;
    tick();
    halt_req = 1'b0; #1;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_valid", 64'(valid_d), 64'd0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; branch_taken = 1'b1; branch_target = 36'd9; stall = 1'(i); #1;
      chk("halt_addr", 64'(imem_addr), 64'd2);
      tick();
      chk("halt_sticky", 64'(halted), 64'd1);
      chk("halt_state", 64'(dbg_state), 64'd2);
    end
    chk("drain_halt", 64'(exp_q.size()), 64'd0);

    // Reset leaves HALT, then refetch from 0
    idle_inputs();
    reset = 1'b1; #1;
    tick();
    chk_cleared("halt_reset");
    reset = 1'b0; start = 1'b1; #1;
    tick();
    start = 1'b0; #1;
    tick();
    chk("refetch_pc", 64'(pc_d), 64'd0);
    chk("refetch_instr", 64'(instr_d), 64'h11);

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      stall        = (r < 25);
      branch_taken = (r >= 20 && r < 32);
      halt_req     = (r == 99);
      start        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        branch_target = 36'hFFFFFFFFF - 36'($urandom_range(0, 3));
      else
        branch_target = 36'($urandom_range(0, 63));
      #1;
      tick();
      if (halted) begin
        chk("rand_drain", 64'(exp_q.size()), 64'd0);
        idle_inputs();
        tick();
        reset = 1'b1; #1;
        tick();
        reset = 1'b0; start = 1'b1; #1;
        tick();
        start = 1'b0; #1;
      end
    end
    idle_inputs();
    tick();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream while stalled
    stall = 1'b1; reset = 1'b1; #1;
    tick();
    chk_cleared("mid_reset");
    reset = 1'b0; stall = 1'b0; #1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
